// File: rtl/sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan_driver
// Brief    : Multiplexed hex seven-segment driver with frame-aligned updates
//            and optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan_driver #(
    parameter int DIGITS           = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter bit ACTIVE_LOW_ANODE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                blank_lz,
    input  logic                enable,
    output logic [6:0]          sevenseg,
    output logic                decout,
    output logic [DIGITS-1:0]   anode,
    output logic                frame_tick
);

    localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  c_anode_idle = ACTIVE_LOW_ANODE ? '1 : '0;
    localparam logic [6:0]         c_seg_blank = 7'b1111111;

    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [4*DIGITS-1:0] r_shadow_val;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [4*DIGITS-1:0] r_active_val;
    logic [DIGITS-1:0]   r_active_dp;
    logic                r_pending;
    logic [6:0]          r_seg;
    logic                r_dec;
    logic [DIGITS-1:0]   r_anode;

    logic                w_cnt_tc;
    logic                w_wrap;
    logic [DIGITS-1:0]   w_sel;
    logic [DIGITS-1:0]   w_lz_mask;
    logic                w_upper_zero;
    logic [3:0]          w_cur_nib;
    logic                w_cur_dp;
    logic                w_cur_blank;

    assign w_cnt_tc = (r_cnt == c_cnt_last);
    assign w_wrap   = w_cnt_tc && (r_idx == c_idx_last);

    // Gated by rst_n so the degenerate 1x1 configuration stays quiet in reset.
    assign frame_tick = w_wrap & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_tc) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A load in the boundary cycle goes straight to active and leaves nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_active_val <= '0;
            r_active_dp  <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_in;
            end
            if (w_wrap) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_active_val <= value;
                    r_active_dp  <= dp_in;
                end else if (r_pending) begin
                    r_active_val <= r_shadow_val;
                    r_active_dp  <= r_shadow_dp;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Digit i is a leading zero when it and every digit above it are zero.
    always_comb begin
        w_lz_mask    = '0;
        w_upper_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_upper_zero = w_upper_zero & (r_active_val[4*i +: 4] == 4'h0);
            w_lz_mask[i] = w_upper_zero;
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
            assign w_sel[gi] = (r_idx == c_idx_w'(gi));
        end
    endgenerate

    always_comb begin
        w_cur_nib   = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_sel[i]) begin
                w_cur_nib   = r_active_val[4*i +: 4];
                w_cur_dp    = r_active_dp[i];
                w_cur_blank = blank_lz & w_lz_mask[i];
            end
        end
    end

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    f_decode = 7'b0000001;
            4'h1:    f_decode = 7'b1001111;
            4'h2:    f_decode = 7'b0010010;
            4'h3:    f_decode = 7'b0000110;
            4'h4:    f_decode = 7'b1001100;
            4'h5:    f_decode = 7'b0100100;
            4'h6:    f_decode = 7'b0100000;
            4'h7:    f_decode = 7'b0001111;
            4'h8:    f_decode = 7'b0000000;
            4'h9:    f_decode = 7'b0000100;
            4'hA:    f_decode = 7'b0001000;
            4'hB:    f_decode = 7'b1100000;
            4'hC:    f_decode = 7'b0110001;
            4'hD:    f_decode = 7'b1000010;
            4'hE:    f_decode = 7'b0110000;
            default: f_decode = 7'b0111000;
        endcase
    endfunction

    // Anode and segments share one register stage so they always change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg   <= c_seg_blank;
            r_dec   <= 1'b1;
            r_anode <= c_anode_idle;
        end else if (enable) begin
            r_seg   <= w_cur_blank ? c_seg_blank : f_decode(w_cur_nib);
            r_dec   <= ~w_cur_dp;
            r_anode <= ACTIVE_LOW_ANODE ? ~w_sel : w_sel;
        end else begin
            r_seg   <= c_seg_blank;
            r_dec   <= 1'b1;
            r_anode <= c_anode_idle;
        end
    end

    assign sevenseg = r_seg;
    assign decout   = r_dec;
    assign anode    = r_anode;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_scan_driver
// Brief    : Self-checking bench: table of frames with a display scoreboard,
//            plus reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan_driver;

    localparam int NV = 9;

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic            blank;
        logic [1:0]      mode;   // 0 mid load, 1 double load, 2 boundary load, 3 enable drop
        logic [3:0][6:0] seg;    // expected segments per digit, [0] = rightmost
    } vec_t;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dec;
    } disp_t;

    localparam disp_t DARK = '{anode: 4'b1111, seg: 7'b1111111, dec: 1'b1};
    localparam disp_t ZERO_D0 = '{anode: 4'b1110, seg: 7'b0000001, dec: 1'b1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        enable;
    logic [6:0]  sevenseg;
    logic        decout;
    logic [3:0]  anode;
    logic        frame_tick;

    vec_t  vec [NV];
    disp_t sb [$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(
        .DIGITS(4),
        .REFRESH_DIV(3),
        .ACTIVE_LOW_ANODE(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .value(value),
        .dp_in(dp_in),
        .blank_lz(blank_lz),
        .enable(enable),
        .sevenseg(sevenseg),
        .decout(decout),
        .anode(anode),
        .frame_tick(frame_tick)
    );

    task automatic check_disp(input string name, input disp_t exp);
        n_checks++;
        if ({anode, sevenseg, decout} !== exp) begin
            n_fail++;
            $display("FAIL %s: got anode=%b seg=%b dp=%b, want anode=%b seg=%b dp=%b",
                     name, anode, sevenseg, decout, exp.anode, exp.seg, exp.dec);
        end
    endtask

    task automatic check_sb(input string name);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got anode=%b seg=%b", name, anode, sevenseg);
        end else begin
            check_disp(name, sb.pop_front());
        end
    endtask

    task automatic check_tick(input string name, input logic exp);
        n_checks++;
        if (frame_tick !== exp) begin
            n_fail++;
            $display("FAIL %s: frame_tick=%b, want %b", name, frame_tick, exp);
        end
    endtask

    task automatic wait_tick(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: frame_tick not seen within 40 cycles, got 0 want 1", name);
        end
    endtask

    task automatic drive_load(input logic [15:0] v, input logic [3:0] d);
        load  = 1'b1;
        value = v;
        dp_in = d;
    endtask

    // Entered just after the negedge of a boundary cycle; vec[v] becomes active on
    // the next edge. Each step pops the display registered on that edge.
    task automatic run_vec(input int v);
        disp_t r;
        bit    do_load = (v < NV - 1);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            load   = 1'b0;
            enable = 1'b1;
            if (c == 0) begin
                blank_lz = vec[v].blank;
                for (int j = 0; j < 12; j++) begin
                    r.anode = ~(4'b0001 << (j / 3));
                    r.seg   = vec[v].seg[j / 3];
                    r.dec   = ~vec[v].dp[j / 3];
                    if (vec[v].mode == 2'd3 && j >= 3 && j <= 7) r = DARK;
                    sb.push_back(r);
                end
            end
            if (vec[v].mode == 2'd3 && c >= 3 && c <= 7) enable = 1'b0;
            if (do_load) begin
                case (vec[v].mode)
                    2'd1: begin
                        if (c == 2) drive_load(16'h2222, 4'b0000);
                        if (c == 6) drive_load(vec[v+1].value, vec[v+1].dp);
                    end
                    2'd2: if (c == 11) drive_load(vec[v+1].value, vec[v+1].dp);
                    default: if (c == 4) drive_load(vec[v+1].value, vec[v+1].dp);
                endcase
            end
            @(negedge clk);
            check_sb($sformatf("vec%0d c%0d disp", v, c));
            check_tick($sformatf("vec%0d c%0d tick", v, c), (c == 11));
        end
    endtask

    initial begin
        vec[0] = '{16'h3A7F, 4'b0100, 1'b0, 2'd0, {7'b0000110, 7'b0001000, 7'b0001111, 7'b0111000}};
        vec[1] = '{16'h0040, 4'b0000, 1'b1, 2'd0, {7'b1111111, 7'b1111111, 7'b1001100, 7'b0000001}};
        vec[2] = '{16'h0000, 4'b0000, 1'b1, 2'd3, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
        vec[3] = '{16'h0000, 4'b0000, 1'b0, 2'd1, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};
        vec[4] = '{16'h5555, 4'b0000, 1'b0, 2'd2, {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}};
        vec[5] = '{16'h8BCD, 4'b1001, 1'b1, 2'd0, {7'b0000000, 7'b1100000, 7'b0110001, 7'b1000010}};
        vec[6] = '{16'h0E06, 4'b1000, 1'b1, 2'd0, {7'b1111111, 7'b0110000, 7'b0000001, 7'b0100000}};
        vec[7] = '{16'h1259, 4'b0010, 1'b0, 2'd0, {7'b1001111, 7'b0010010, 7'b0100100, 7'b0000100}};
        vec[8] = '{16'h1111, 4'b0000, 1'b0, 2'd0, {7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111}};

        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;
        enable   = 1'b1;

        repeat (2) @(negedge clk);
        check_disp("reset state", DARK);
        check_tick("reset tick", 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_disp("first cycle after reset", ZERO_D0);

        @(posedge clk);
        #1 drive_load(vec[0].value, vec[0].dp);
        @(posedge clk);
        #1 load = 1'b0;
        wait_tick("first boundary");
        sb.push_back('{anode: 4'b0111, seg: 7'b0000001, dec: 1'b1});

        for (int v = 0; v < NV; v++) run_vec(v);
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        check_sb("last frame tail");

        // Asynchronous reset mid-frame with a load still pending.
        @(posedge clk);
        #1 drive_load(16'hABCD, 4'b1111);
        @(posedge clk);
        #1 load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_disp("async reset mid-scan", DARK);
        check_tick("async reset tick", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_disp("restart after reset", ZERO_D0);
        wait_tick("boundary after reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_disp("pending discarded by reset", ZERO_D0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
